// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : State encodings, grant identifiers and width codes shared by the
//            memory port arbiter and its grant selector.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2,
      ARB_DONE    = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_DM = 1'b1
   } grant_t;

   localparam logic [1:0] MEM_W_BYTE = 2'b00;
   localparam logic [1:0] MEM_W_HALF = 2'b01;
   localparam logic [1:0] MEM_W_WORD = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_grant.sv
// ============================================================================
// Module   : mem_arb_grant
// Brief    : Combinational winner select between IF and DM requesters.
//            MEM_ARB_RR_EN defined: ties go to the requester not granted last.
//            MEM_ARB_RR_EN undefined: ties always go to DM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_grant
   import mem_port_arbiter_pkg::*;
(
   input  logic   if_req,
   input  logic   dm_req,
   input  grant_t last_grant,
   output logic   grant_valid,
   output grant_t grant
);

`ifdef MEM_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   always_comb begin
      grant_valid = if_req | dm_req;
      grant       = GRANT_DM;
      if (if_req && !dm_req) begin
         grant = GRANT_IF;
      end else if (if_req && dm_req && RR_EN && (last_grant == GRANT_DM)) begin
         grant = GRANT_IF;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and load/store,
//            holding each request until the memory signals ready, then
//            returning data and a one-cycle ack. Sticky timeout error flag.
//            Optional round-robin tie-break via MEM_ARB_RR_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [1:0]        dm_width_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ack_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [1:0]        mem_width_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              err_o
);

   // Counter value during the busy cycle in which the wait reaches TIMEOUT.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   arb_state_t  state;
   grant_t      last_grant;
   grant_t      grant;
   logic        grant_valid;
   logic [15:0] wait_cnt;

   mem_arb_grant u_grant (
      .if_req      (if_req_i),
      .dm_req      (dm_req_i),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ARB_IDLE;
         last_grant  <= GRANT_DM;
         wait_cnt    <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_width_o <= 2'b00;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_rdata_o  <= '0;
         dm_rdata_o  <= '0;
         if_ack_o    <= 1'b0;
         dm_ack_o    <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         if_ack_o <= 1'b0;
         dm_ack_o <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  mem_req_o  <= 1'b1;
                  wait_cnt   <= '0;
                  last_grant <= grant;
                  if (grant == GRANT_DM) begin
                     mem_we_o    <= dm_we_i;
                     mem_width_o <= dm_width_i;
                     mem_addr_o  <= dm_addr_i;
                     mem_wdata_o <= dm_wdata_i;
                     state       <= ARB_BUSY_DM;
                  end else begin
                     mem_we_o    <= 1'b0;
                     mem_width_o <= MEM_W_WORD;
                     mem_addr_o  <= if_addr_i;
                     mem_wdata_o <= '0;
                     state       <= ARB_BUSY_IF;
                  end
               end
            end
            ARB_BUSY_IF, ARB_BUSY_DM: begin
               // Saturating count; the error only flags, the access keeps waiting.
               if (wait_cnt != 16'hFFFF) begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
               if (wait_cnt >= TO_LAST) begin
                  err_o <= 1'b1;
               end
               if (mem_ready_i) begin
                  mem_req_o <= 1'b0;
                  state     <= ARB_DONE;
                  if (state == ARB_BUSY_IF) begin
                     if_rdata_o <= mem_rdata_i;
                     if_ack_o   <= 1'b1;
                  end else begin
                     if (!mem_we_o) begin
                        dm_rdata_o <= mem_rdata_i;
                     end
                     dm_ack_o <= 1'b1;
                  end
               end
            end
            ARB_DONE: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter (TIMEOUT=4); follows
//            MEM_ARB_RR_EN for the expected tie-break order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [1:0]  dm_width = 2'b00;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        err;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_rdata_o  (if_rdata),
      .if_ack_o    (if_ack),
      .dm_req_i    (dm_req),
      .dm_we_i     (dm_we),
      .dm_width_i  (dm_width),
      .dm_addr_i   (dm_addr),
      .dm_wdata_i  (dm_wdata),
      .dm_rdata_o  (dm_rdata),
      .dm_ack_o    (dm_ack),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_width_o (mem_width),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ready_i (mem_ready),
      .err_o       (err)
   );

   int          checks = 0;
   int          failures = 0;
   bit          exp_last_dm = 1'b1;
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_dm_rd = '0;
   bit          exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Tie-break rule: fixed priority favours DM, round-robin favours whoever lost last.
   function automatic bit pick_dm(input bit ir, input bit dr, input bit last_dm);
      if (!ir) return 1'b1;
      if (!dr) return 1'b0;
`ifdef MEM_ARB_RR_EN
      return !last_dm;
`else
      return 1'b1;
`endif
   endfunction

   // Called in IDLE with requests already presented; returns in IDLE one cycle after DONE.
   task automatic run_txn(input int lat, input logic [31:0] rd, input bit drop_early);
      bit          w_dm;
      logic        e_we;
      logic [1:0]  e_w;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      int          busy;
      w_dm   = pick_dm(if_req, dm_req, exp_last_dm);
      e_we   = w_dm ? dm_we : 1'b0;
      e_w    = w_dm ? dm_width : 2'b10;
      e_addr = w_dm ? dm_addr : if_addr;
      e_wd   = dm_wdata;
      @(posedge clk); #1;
      exp_last_dm = w_dm;
      chk("grant_req", mem_req, 1);
      chk("grant_we", mem_we, e_we);
      chk("grant_width", mem_width, e_w);
      chk("grant_addr", mem_addr, e_addr);
      if (w_dm && e_we) chk("grant_wdata", mem_wdata, e_wd);
      if (drop_early) begin
         if (w_dm) dm_req = 1'b0; else if_req = 1'b0;
      end
      busy = 0;
      for (int k = 0; k < lat; k++) begin
         @(posedge clk); #1;
         busy++;
         if (busy >= TO) exp_err = 1'b1;
         chk("busy_req", mem_req, 1);
         chk("busy_addr", mem_addr, e_addr);
         chk("busy_ack", {if_ack, dm_ack}, 0);
         chk("busy_err", err, exp_err);
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      busy++;
      if (busy >= TO) exp_err = 1'b1;
      if (w_dm) begin
         if (!e_we) exp_dm_rd = rd;
      end else begin
         exp_if_rd = rd;
      end
      chk("done_ack", {if_ack, dm_ack}, w_dm ? 2'b01 : 2'b10);
      chk("done_req", mem_req, 0);
      chk("done_if_rdata", if_rdata, exp_if_rd);
      chk("done_dm_rdata", dm_rdata, exp_dm_rd);
      chk("done_err", err, exp_err);
      if (w_dm) dm_req = 1'b0; else if_req = 1'b0;
      @(posedge clk); #1;
      chk("post_ack", {if_ack, dm_ack}, 0);
      chk("post_if_rdata", if_rdata, exp_if_rd);
      chk("post_dm_rdata", dm_rdata, exp_dm_rd);
      chk("post_err", err, exp_err);
   endtask

   initial begin
      int r;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_acks", {if_ack, dm_ack}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_ctl", {mem_we, mem_width}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Spurious ready while idle
      mem_ready = 1'b1;
      mem_rdata = 32'h12345678;
      repeat (2) begin
         @(posedge clk); #1;
         chk("spur_acks", {if_ack, dm_ack}, 0);
         chk("spur_req", mem_req, 0);
         chk("spur_if_rdata", if_rdata, 0);
         chk("spur_dm_rdata", dm_rdata, 0);
      end
      mem_ready = 1'b0;
      @(posedge clk); #1;

      // IF fetch, ready two cycles after request
      if_req  = 1'b1;
      if_addr = 32'h40;
      run_txn(1, 32'h00500093, 1'b0);

      // DM byte store leaves dm_rdata untouched
      dm_req = 1'b1; dm_we = 1'b1; dm_width = 2'b00;
      dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
      run_txn(0, 32'hA5A5A5A5, 1'b0);

      // Two simultaneous-request ties
      repeat (2) begin
         if_req = 1'b1; if_addr = 32'h200;
         dm_req = 1'b1; dm_we = 1'b0; dm_width = 2'b10; dm_addr = 32'h300;
         while (if_req || dm_req) run_txn($urandom_range(0, 2), $urandom, 1'b0);
      end

      // Randomized mixes
      for (int n = 0; n < 25; n++) begin
         r        = $urandom_range(1, 3);
         if_req   = r[0];
         dm_req   = r[1];
         if_addr  = $urandom;
         dm_addr  = $urandom;
         dm_we    = 1'($urandom_range(0, 1));
         dm_width = 2'($urandom_range(0, 2));
         dm_wdata = $urandom;
         while (if_req || dm_req)
            run_txn($urandom_range(0, 2), $urandom, $urandom_range(0, 3) == 0);
      end

      // Reset in the middle of a DM access
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h480;
      @(posedge clk); #1;
      chk("rstmid_grant", mem_req, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid_req_async", mem_req, 0);
      chk("rstmid_ack", dm_ack, 0);
      dm_req = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_ack2", dm_ack, 0);
      rst = 1'b0;
      exp_last_dm = 1'b1;
      exp_if_rd   = '0;
      exp_dm_rd   = '0;
      exp_err     = 1'b0;
      chk("rstmid_if_rdata", if_rdata, 0);
      chk("rstmid_err", err, 0);
      @(posedge clk); #1;
      chk("rstmid_idle_req", mem_req, 0);
      chk("rstmid_idle_ack", {if_ack, dm_ack}, 0);

      // First tie after reset
      if_req = 1'b1; if_addr = 32'h500;
      dm_req = 1'b1; dm_we = 1'b1; dm_width = 2'b01; dm_addr = 32'h600; dm_wdata = 32'h0BADF00D;
      while (if_req || dm_req) run_txn($urandom_range(0, 2), $urandom, 1'b0);

      // Memory withholds ready past TIMEOUT; error is sticky after late completion
      dm_req = 1'b1; dm_we = 1'b0; dm_width = 2'b10; dm_addr = 32'h700;
      run_txn(6, 32'hCAFEF00D, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("timeout_sticky", err, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
